inst_cache: RTL



---
 rtl/inst_cache.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache; misses refill one 32-bit line via four byte reads.
// Latency: hit done the cycle after the address is stable; miss done one cycle after the 4th byte response.
// Backpressure: request address/valid hold until mem_req_ready; rdy=0 freezes everything. Option: ICACHE_PERF_COUNTER_EN.
module inst_cache #(
    parameter int ADDR_WIDTH  = 17,
    parameter int INST_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] inst_cache_read_addr,
    output logic                  inst_cache_read_done,
    output logic [INST_WIDTH-1:0] inst_cache_read_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [7:0]            mem_resp_data
`ifdef ICACHE_PERF_COUNTER_EN
    ,
    output logic [31:0]           perf_hit_count,
    output logic [31:0]           perf_miss_count
`endif
);

    localparam int TAG_WIDTH = ADDR_WIDTH - 2 - INDEX_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]      valid_q;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [INST_WIDTH-1:0] data_mem [LINES];

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [INST_WIDTH-1:0] data_q;
    logic                  done_q;
    logic [2:0]            req_cnt_q;
    logic [2:0]            resp_cnt_q;
    logic                  flush_seen_q;
    logic [23:0]           line_buf_q;

    logic [INDEX_WIDTH-1:0] cur_idx, fill_idx;
    logic [TAG_WIDTH-1:0]   cur_tag, fill_tag;
    logic                   addr_match, cur_hit;

    logic lookup_hit, lookup_miss, flush_idle, flush_refill;
    logic req_fire, resp_fire, fill_done, install;

    logic unused_addr_bits;
    assign unused_addr_bits = ^inst_cache_read_addr[1:0];

    assign cur_idx  = inst_cache_read_addr[INDEX_WIDTH+1:2];
    assign cur_tag  = inst_cache_read_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign fill_idx = addr_q[INDEX_WIDTH+1:2];
    assign fill_tag = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];

    assign addr_match = (addr_q[ADDR_WIDTH-1:2] == inst_cache_read_addr[ADDR_WIDTH-1:2]);
    assign cur_hit    = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    // done is qualified by the live address so a changed fetch address never sees a stale word
    assign inst_cache_read_done = done_q && addr_match;
    assign inst_cache_read_data = data_q;
    assign mem_req_addr         = {addr_q[ADDR_WIDTH-1:2], req_cnt_q[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        lookup_hit    = 1'b0;
        lookup_miss   = 1'b0;
        flush_idle    = 1'b0;
        flush_refill  = 1'b0;
        req_fire      = 1'b0;
        resp_fire     = 1'b0;
        fill_done     = 1'b0;
        install       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rdy) begin
                    if (flush) begin
                        flush_idle = 1'b1;
                    end else if (!(done_q && addr_match)) begin
                        if (cur_hit) begin
                            lookup_hit = 1'b1;
                        end else begin
                            lookup_miss = 1'b1;
                            state_d     = REFILL;
                        end
                    end
                end
            end
            REFILL: begin
                mem_req_valid = !req_cnt_q[2];
                if (rdy) begin
                    flush_refill = flush;
                    req_fire     = mem_req_valid && mem_req_ready;
                    resp_fire    = mem_resp_valid;
                    if (mem_resp_valid && resp_cnt_q == 3'd3) begin
                        fill_done = 1'b1;
                        // a flush landing with the last byte also keeps the line out
                        install   = !flush_seen_q && !flush;
                        state_d   = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            req_cnt_q    <= 3'd0;
            resp_cnt_q   <= 3'd0;
            flush_seen_q <= 1'b0;
            line_buf_q   <= 24'd0;
        end else begin
            if (flush_idle || flush_refill) begin
                valid_q <= '0;
            end else if (install) begin
                valid_q[fill_idx] <= 1'b1;
            end
            if (flush_idle) begin
                done_q <= 1'b0;
            end
            if (lookup_hit) begin
                data_q <= data_mem[cur_idx];
                addr_q <= inst_cache_read_addr;
                done_q <= 1'b1;
            end
            if (lookup_miss) begin
                addr_q     <= inst_cache_read_addr;
                done_q     <= 1'b0;
                req_cnt_q  <= 3'd0;
                resp_cnt_q <= 3'd0;
            end
            if (req_fire) begin
                req_cnt_q <= req_cnt_q + 3'd1;
            end
            if (flush_refill) begin
                flush_seen_q <= 1'b1;
            end
            if (resp_fire) begin
                resp_cnt_q <= resp_cnt_q + 3'd1;
                case (resp_cnt_q[1:0])
                    2'd0:    line_buf_q[7:0]   <= mem_resp_data;
                    2'd1:    line_buf_q[15:8]  <= mem_resp_data;
                    2'd2:    line_buf_q[23:16] <= mem_resp_data;
                    default: ;
                endcase
            end
            if (fill_done) begin
                data_q       <= {mem_resp_data, line_buf_q};
                done_q       <= 1'b1;
                flush_seen_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= {mem_resp_data, line_buf_q};
        end
    end

`ifdef ICACHE_PERF_COUNTER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hit_count  <= 32'd0;
            perf_miss_count <= 32'd0;
        end else begin
            if (lookup_hit) begin
                perf_hit_count <= perf_hit_count + 32'd1;
            end
            if (lookup_miss) begin
                perf_miss_count <= perf_miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
